spgd_perturb_seq: RTL

SPGD_PERTURB_SEQ -- requirements
Module: spgd_perturb_seq

---
 rtl/spgd_perturb_seq_pkg.sv | 32 +++
 rtl/spgd_lfsr.sv | 22 ++
 rtl/spgd_perturb_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spgd_perturb_seq_pkg.sv
// Shared types and constants for the SPGD perturbation sequencer.
package spgd_perturb_seq_pkg;

    localparam int unsigned DEF_ADC_WIDTH     = 12;
    localparam int unsigned DEF_DAC_WIDTH     = 14;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned LFSR_WIDTH        = 16;

    localparam logic [13:0] DEF_DELTA_MAG = 14'h0040;
    localparam logic [13:0] DEF_U_INIT    = 14'h2000;

    localparam logic [LFSR_WIDTH-1:0] DEF_LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask on state bits [15],[13],[12],[10]
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE_P,
        ST_SETTLE_P,
        ST_SAMPLE_P,
        ST_DRIVE_M,
        ST_SETTLE_M,
        ST_SAMPLE_M,
        ST_UPDATE
    } state_t;

    // One Fibonacci step: shift left, feedback enters at bit 0
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/spgd_lfsr.sv
// 16-bit Fibonacci LFSR supplying perturbation signs; a nonzero seed keeps it off the all-zero lock-up state.
module spgd_lfsr
    import spgd_perturb_seq_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEF_LFSR_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] state
);

    // Advance one step per enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/spgd_perturb_seq.sv
// SPGD iteration sequencer: drives +delta and -delta perturbations, captures both metrics, then loads the updated control.
module spgd_perturb_seq
    import spgd_perturb_seq_pkg::*;
#(
    parameter int unsigned          ADC_WIDTH     = DEF_ADC_WIDTH,
    parameter int unsigned          DAC_WIDTH     = DEF_DAC_WIDTH,
    parameter int unsigned          SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [DAC_WIDTH-1:0] DELTA_MAG     = DAC_WIDTH'(DEF_DELTA_MAG),
    parameter logic [DAC_WIDTH-1:0] U_INIT        = DAC_WIDTH'(DEF_U_INIT),
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [DAC_WIDTH-1:0] dac0,
    output logic [DAC_WIDTH-1:0] dac1,
    output logic                 dac_load,
    output logic [ADC_WIDTH-1:0] J_p,
    output logic [ADC_WIDTH-1:0] J_m,
    output logic [DAC_WIDTH-1:0] U0,
    output logic [DAC_WIDTH-1:0] U1,
    output logic [DAC_WIDTH-1:0] DELTA_U0,
    output logic [DAC_WIDTH-1:0] DELTA_U1,
    input  logic [DAC_WIDTH-1:0] new_U0,
    input  logic [DAC_WIDTH-1:0] new_U1,
    output logic                 busy,
    output logic                 iter_done
);

    localparam int unsigned          CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DAC_WIDTH-1:0] DELTA_NEG = DAC_WIDTH'(0) - DELTA_MAG;

    // u +/- DELTA_MAG in a wider word; top bit flags underflow, next bit flags overflow
    function automatic logic [DAC_WIDTH-1:0] sat_add(input logic [DAC_WIDTH-1:0] u, input logic neg);
        logic [DAC_WIDTH+1:0] sum;
        sum = neg ? ({2'b00, u} - {2'b00, DELTA_MAG}) : ({2'b00, u} + {2'b00, DELTA_MAG});
        if (sum[DAC_WIDTH+1]) begin
            return '0;
        end else if (sum[DAC_WIDTH]) begin
            return '1;
        end
        return sum[DAC_WIDTH-1:0];
    endfunction

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   sign0, sign0_n, sign1, sign1_n;
    logic [DAC_WIDTH-1:0]   u0_n, u1_n, du0_n, du1_n, dac0_n, dac1_n;
    logic [ADC_WIDTH-1:0]   jp_n, jm_n;
    logic                   busy_n, dac_load_n, iter_done_n;
    logic                   lfsr_step;
    logic [LFSR_WIDTH-1:0]  lfsr_state;
    logic [1:0]             sign_pair_c;

    spgd_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Signs come from the post-step LFSR value so they latch on the same edge the LFSR advances
    assign sign_pair_c = 2'(lfsr_next(lfsr_state));

    // Next-state and next-register-value logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sign0_n     = sign0;
        sign1_n     = sign1;
        u0_n        = U0;
        u1_n        = U1;
        du0_n       = DELTA_U0;
        du1_n       = DELTA_U1;
        dac0_n      = dac0;
        dac1_n      = dac1;
        jp_n        = J_p;
        jm_n        = J_m;
        busy_n      = busy;
        dac_load_n  = 1'b0;
        iter_done_n = 1'b0;
        lfsr_step   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_DRIVE_P;
                    busy_n    = 1'b1;
                    lfsr_step = 1'b1;
                    sign0_n   = sign_pair_c[0];
                    sign1_n   = sign_pair_c[1];
                    du0_n     = sign_pair_c[0] ? DELTA_NEG : DELTA_MAG;
                    du1_n     = sign_pair_c[1] ? DELTA_NEG : DELTA_MAG;
                end
            end
            ST_DRIVE_P: begin
                dac0_n     = sat_add(U0, sign0);
                dac1_n     = sat_add(U1, sign1);
                dac_load_n = 1'b1;
                cnt_n      = '0;
                state_n    = ST_SETTLE_P;
            end
            ST_SETTLE_P: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE_P;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE_P: begin
                if (adc_valid) begin
                    jp_n    = adc_data;
                    state_n = ST_DRIVE_M;
                end
            end
            ST_DRIVE_M: begin
                dac0_n     = sat_add(U0, !sign0);
                dac1_n     = sat_add(U1, !sign1);
                dac_load_n = 1'b1;
                cnt_n      = '0;
                state_n    = ST_SETTLE_M;
            end
            ST_SETTLE_M: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_SAMPLE_M;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE_M: begin
                if (adc_valid) begin
                    jm_n    = adc_data;
                    state_n = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                u0_n        = new_U0;
                u1_n        = new_U1;
                dac0_n      = new_U0;
                dac1_n      = new_U1;
                dac_load_n  = 1'b1;
                iter_done_n = 1'b1;
                busy_n      = 1'b0;
                state_n     = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset restores the idle control point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sign0     <= 1'b0;
            sign1     <= 1'b0;
            U0        <= U_INIT;
            U1        <= U_INIT;
            DELTA_U0  <= DELTA_MAG;
            DELTA_U1  <= DELTA_MAG;
            dac0      <= U_INIT;
            dac1      <= U_INIT;
            J_p       <= '0;
            J_m       <= '0;
            busy      <= 1'b0;
            dac_load  <= 1'b0;
            iter_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sign0     <= sign0_n;
            sign1     <= sign1_n;
            U0        <= u0_n;
            U1        <= u1_n;
            DELTA_U0  <= du0_n;
            DELTA_U1  <= du1_n;
            dac0      <= dac0_n;
            dac1      <= dac1_n;
            J_p       <= jp_n;
            J_m       <= jm_n;
            busy      <= busy_n;
            dac_load  <= dac_load_n;
            iter_done <= iter_done_n;
        end
    end

endmodule
